// File: rtl/imem_loader_if.sv
// Byte-stream receive channel and instruction-memory write port of the loader.
// slave  : the loader side (consumes rx bytes, drives memory writes).
// master : the environment side (supplies rx bytes, observes memory writes).
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory.
// Latency: one write strobe in the cycle after the 4th byte of each word is accepted.
// Backpressure: rx_ready is high only while loading; rx_valid=0 simply stalls.
// Ports: clk, reset_n (sync, active low), start; bus (rx byte channel + imem
// write port); cpu_hold, busy, done, error status.
module imem_loader #(
    parameter int MEM_DEPTH = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         busy,
    output logic         done,
    output logic         error
);

    typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERR} state_t;

    localparam logic [15:0] DEPTH_W = 16'(MEM_DEPTH);

    state_t      state_q, state_d;
    logic        rx_ready_q;
    logic        we_q;
    logic [31:0] waddr_q;
    logic [31:0] wdata_q;
    logic        len_hi_q;     // low length byte already captured
    logic [7:0]  len_lo_q;
    logic [15:0] nwords_q;
    logic [1:0]  lane_q;
    logic [15:0] word_idx_q;
    logic [23:0] shift_q;      // bytes 0..2 of the word in progress, newest on top

    logic        accept;
    logic [15:0] len_word;
    logic        last_byte;
    logic        last_word;

    assign accept    = bus.rx_valid & rx_ready_q;
    assign len_word  = {bus.rx_data, len_lo_q};
    assign last_byte = (lane_q == 2'd3);
    assign last_word = (word_idx_q == nwords_q - 16'd1);

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LEN;
            end
            LEN: begin
                busy = 1'b1;
                if (accept && len_hi_q) begin
                    if (len_word == 16'd0)       state_d = DONE;
                    else if (len_word > DEPTH_W) state_d = ERR;
                    else                         state_d = DATA;
                end
            end
            DATA: begin
                busy = 1'b1;
                // Leave in the same edge that launches the final write strobe.
                if (accept && last_byte && last_word) state_d = DONE;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_d = LEN;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_d = LEN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            len_hi_q   <= 1'b0;
            len_lo_q   <= '0;
            nwords_q   <= '0;
            lane_q     <= '0;
            word_idx_q <= '0;
            shift_q    <= '0;
        end else begin
            we_q       <= 1'b0;
            // Registered from the next state so it lines up with the state it describes.
            rx_ready_q <= (state_d == LEN) || (state_d == DATA);

            // Every (re)start begins a fresh transfer from word 0.
            if (state_d == LEN && state_q != LEN) begin
                len_hi_q   <= 1'b0;
                lane_q     <= '0;
                word_idx_q <= '0;
            end

            if (state_q == LEN && accept) begin
                if (!len_hi_q) begin
                    len_lo_q <= bus.rx_data;
                    len_hi_q <= 1'b1;
                end else begin
                    nwords_q <= len_word;
                end
            end

            if (state_q == DATA && accept) begin
                lane_q <= lane_q + 2'd1;
                if (last_byte) begin
                    we_q    <= 1'b1;
                    waddr_q <= {14'd0, word_idx_q, 2'b00};
                    wdata_q <= {bus.rx_data, shift_q};
                    if (!last_word) word_idx_q <= word_idx_q + 16'd1;
                end else begin
                    shift_q <= {bus.rx_data, shift_q[23:8]};
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, stalls, length limits,
// start while busy / restart, and reset in the middle of a load.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic cpu_hold, busy, done, error;

    imem_loader_if bus ();

    imem_loader #(.MEM_DEPTH(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [7:0]  stream[$];

    // Record every write strobe seen, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wq_addr.push_back(bus.imem_waddr);
            wq_data.push_back(bus.imem_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] a, d;
        a = (idx < wq_addr.size()) ? wq_addr[idx] : 32'hDEAD_BEEF;
        d = (idx < wq_data.size()) ? wq_data[idx] : 32'hDEAD_BEEF;
        check({tag, "_addr"}, a, addr);
        check({tag, "_data"}, d, data);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte and hold it until the loader takes it (bounded wait).
    task automatic send_byte(input logic [7:0] b, input bit stall);
        if (stall) begin
            bus.rx_valid = 1'b0;
            tick();
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 16 && bus.rx_ready !== 1'b1; i++) tick();
        check("rx_ready_wait", {31'd0, bus.rx_ready}, 32'd1);
        tick();
    endtask

    task automatic send_stream(input bit stalls);
        for (int i = 0; i < stream.size(); i++)
            send_byte(stream[i], stalls && (i % 3 != 1));
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
        check({tag, "_we"},       {31'd0, bus.imem_we},  32'd0);
        check({tag, "_waddr"},    bus.imem_waddr,        32'd0);
        check({tag, "_wdata"},    bus.imem_wdata,        32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold},     32'd1);
        check({tag, "_busy"},     {31'd0, busy},         32'd0);
        check({tag, "_done"},     {31'd0, done},         32'd0);
        check({tag, "_error"},    {31'd0, error},        32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();
        check("idle_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("idle_rx_ready", {31'd0, bus.rx_ready}, 32'd0);

        // Two-word load with rx_valid held high.
        clear_writes();
        pulse_start();
        check("len_busy", {31'd0, busy}, 32'd1);
        check("len_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        stream = '{8'h02, 8'h00, 8'hEF, 8'h02, 8'h80, 8'h00, 8'h6F, 8'hF0, 8'hDF, 8'hFF};
        send_stream(1'b0);
        check("last_we", {31'd0, bus.imem_we}, 32'd1);
        check("last_waddr", bus.imem_waddr, 32'h4);
        check("last_wdata", bus.imem_wdata, 32'hFFDF_F06F);
        check("last_done", {31'd0, done}, 32'd1);
        tick();
        check("after_we", {31'd0, bus.imem_we}, 32'd0);
        check("after_done", {31'd0, done}, 32'd1);
        check("after_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("after_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        check("hold_waddr", bus.imem_waddr, 32'h4);
        check("hold_wdata", bus.imem_wdata, 32'hFFDF_F06F);
        check("load_nwrites", wq_addr.size(), 32'd2);
        check_write("load_w0", 0, 32'h0, 32'h0080_02EF);
        check_write("load_w1", 1, 32'h4, 32'hFFDF_F06F);

        // Restart from DONE, with a start pulse ignored mid-DATA.
        clear_writes();
        pulse_start();
        check("restart_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("restart_done", {31'd0, done}, 32'd0);
        stream = '{8'h02, 8'h00, 8'h44, 8'h33};
        send_stream(1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_data_busy", {31'd0, busy}, 32'd1);
        check("start_in_data_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        stream = '{8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
        send_stream(1'b0);
        tick();
        check("reload_done", {31'd0, done}, 32'd1);
        check("reload_nwrites", wq_addr.size(), 32'd2);
        check_write("reload_w0", 0, 32'h0, 32'h1122_3344);
        check_write("reload_w1", 1, 32'h4, 32'h5566_7788);

        // Same stream as the first load with idle cycles interleaved.
        clear_writes();
        pulse_start();
        stream = '{8'h02, 8'h00, 8'hEF, 8'h02, 8'h80, 8'h00, 8'h6F, 8'hF0, 8'hDF, 8'hFF};
        send_stream(1'b1);
        tick();
        tick();
        check("stall_done", {31'd0, done}, 32'd1);
        check("stall_nwrites", wq_addr.size(), 32'd2);
        check_write("stall_w0", 0, 32'h0, 32'h0080_02EF);
        check_write("stall_w1", 1, 32'h4, 32'hFFDF_F06F);

        // Zero-length load.
        clear_writes();
        pulse_start();
        stream = '{8'h00, 8'h00};
        send_stream(1'b0);
        check("n0_done", {31'd0, done}, 32'd1);
        check("n0_busy", {31'd0, busy}, 32'd0);
        check("n0_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("n0_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        tick();
        check("n0_nwrites", wq_addr.size(), 32'd0);

        // Length one past the memory depth.
        pulse_start();
        stream = '{8'h21, 8'h00};
        send_stream(1'b0);
        check("n33_error", {31'd0, error}, 32'd1);
        check("n33_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("n33_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        check("n33_busy", {31'd0, busy}, 32'd0);
        bus.rx_data  = 8'hAA;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        bus.rx_valid = 1'b0;
        check("n33_still_error", {31'd0, error}, 32'd1);
        check("n33_nwrites", wq_addr.size(), 32'd0);

        // Length exactly at the memory depth is accepted, then abort by reset
        // with start and rx_valid also asserted.
        pulse_start();
        stream = '{8'h20, 8'h00};
        send_stream(1'b0);
        check("n32_busy", {31'd0, busy}, 32'd1);
        check("n32_error", {31'd0, error}, 32'd0);
        check("n32_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        reset_n      = 1'b0;
        start        = 1'b1;
        bus.rx_valid = 1'b1;
        tick();
        check_reset_outputs("rst_prio");
        reset_n      = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        tick();

        // Reset after the 6th DATA byte: word 0 written, word 1 never.
        clear_writes();
        pulse_start();
        stream = '{8'h02, 8'h00, 8'hEF, 8'h02, 8'h80, 8'h00, 8'h6F, 8'hF0};
        send_stream(1'b0);
        reset_n      = 1'b0;
        start        = 1'b1;
        bus.rx_data  = 8'hDF;
        bus.rx_valid = 1'b1;
        tick();
        check_reset_outputs("rst_mid");
        reset_n = 1'b1;
        start   = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        bus.rx_valid = 1'b0;
        check("rst_mid_idle_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_idle_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_mid_nwrites", wq_addr.size(), 32'd1);
        check_write("rst_mid_w0", 0, 32'h0, 32'h0080_02EF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
